// File: rtl/fetch_req_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_req_ctrl
//   Instruction fetch request stage placed after the PC selection mux. It
//   issues word-aligned requests on the instruction bus (req/gnt/rvalid),
//   tracks granted-but-unanswered requests, drops responses made stale by a
//   redirect and buffers returned words with their addresses in a small
//   circular FIFO that feeds decode over a valid/ready handshake.
//
//   Optional build macro: FETCH_ERR_STOP_EN
//     defined   : after an errored entry is buffered, no further requests are
//                 issued until the next pc_set_i.
//     undefined : errors are only tagged on the entry; fetching continues.
//
// Ports
//   clk_i, rst_i         core clock, asynchronous active-high reset
//   req_i                fetch enable from the controller
//   pc_set_i             redirect strobe, loads fetch_addr_n_i (word aligned)
//   fetch_addr_n_i       next fetch address from the PC mux
//   instr_req_o          bus request
//   instr_addr_o         bus request address (word aligned)
//   instr_gnt_i          bus grant
//   instr_rvalid_i       bus response valid
//   instr_rdata_i        bus response data
//   instr_err_i          bus response error (qualified by instr_rvalid_i)
//   fetch_valid_o        FIFO head valid
//   fetch_ready_i        decode accepts the head entry
//   fetch_rdata_o        head instruction word
//   fetch_addr_o         head instruction address
//   fetch_err_o          head fetch error
//   busy_o               request pending or responses outstanding
// -----------------------------------------------------------------------------
module fetch_req_ctrl #(
   parameter int FifoDepth      = 2,
   parameter int MaxOutstanding = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        pc_set_i,
   input  logic [31:0] fetch_addr_n_i,
   output logic        instr_req_o,
   output logic [31:0] instr_addr_o,
   input  logic        instr_gnt_i,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   input  logic        instr_err_i,
   output logic        fetch_valid_o,
   input  logic        fetch_ready_i,
   output logic [31:0] fetch_rdata_o,
   output logic [31:0] fetch_addr_o,
   output logic        fetch_err_o,
   output logic        busy_o
);

   // Counters share one width: outstanding never exceeds FifoDepth.
   localparam int CW = $clog2(FifoDepth + 1);
   localparam int PW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam logic [CW-1:0] MAX_OUT   = CW'(MaxOutstanding);
   localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(FifoDepth);
   localparam logic [PW-1:0] LAST_PTR  = PW'(FifoDepth - 1);
   localparam logic [CW-1:0] ONE_C     = {{(CW-1){1'b0}}, 1'b1};

   logic [31:0]   req_addr_q,  req_addr_d;
   logic [31:0]   resp_addr_q, resp_addr_d;
   logic [CW-1:0] outst_q,     outst_d;
   logic [CW-1:0] discard_q,   discard_d;
   logic [CW-1:0] cnt_q,       cnt_d;
   logic [PW-1:0] wr_ptr_q,    wr_ptr_d;
   logic [PW-1:0] rd_ptr_q,    rd_ptr_d;

   logic [31:0]   data_q [FifoDepth];
   logic [31:0]   addr_q [FifoDepth];
   logic          err_q  [FifoDepth];

   logic [31:0]   aligned_s;
   logic          req_s;
   logic          gnt_s;
   logic          push_s;
   logic          pop_s;
   logic          valid_s;
   logic          err_stop_s;
   logic [CW:0]   occupancy_s;

   assign aligned_s   = fetch_addr_n_i & 32'hFFFF_FFFC;
   assign valid_s     = (cnt_q != {CW{1'b0}});
   // Space is reserved in the FIFO for every response still in flight.
   assign occupancy_s = {1'b0, outst_q} + {1'b0, cnt_q};

   assign req_s  = ~rst_i & req_i & ~pc_set_i & ~err_stop_s &
                   (outst_q < MAX_OUT) & (occupancy_s < DEPTH_EXT);
   assign gnt_s  = req_s & instr_gnt_i;
   // A response is stale if it belongs to a pre-redirect request, or if it
   // coincides with the redirect itself.
   assign push_s = instr_rvalid_i & ~pc_set_i & (discard_q == {CW{1'b0}});
   assign pop_s  = valid_s & fetch_ready_i & ~pc_set_i;

`ifdef FETCH_ERR_STOP_EN
   logic err_stop_q, err_stop_d;

   // Error-stop flag: set when an errored entry is buffered, cleared by redirect.
   always_comb begin
      err_stop_d = err_stop_q;
      if (pc_set_i) begin
         err_stop_d = 1'b0;
      end else if (push_s && instr_err_i) begin
         err_stop_d = 1'b1;
      end else begin
         err_stop_d = err_stop_q;
      end
   end

   // Error-stop flag register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_stop_q <= 1'b0;
      end else begin
         err_stop_q <= err_stop_d;
      end
   end

   assign err_stop_s = err_stop_q;
`else
   assign err_stop_s = 1'b0;
`endif

   // Next-state logic for addresses, counters and FIFO pointers.
   always_comb begin
      req_addr_d  = req_addr_q;
      resp_addr_d = resp_addr_q;
      outst_d     = outst_q;
      discard_d   = discard_q;
      cnt_d       = cnt_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;

      if (pc_set_i) begin
         req_addr_d = aligned_s;
      end else if (gnt_s) begin
         req_addr_d = req_addr_q + 32'd4;
      end else begin
         req_addr_d = req_addr_q;
      end

      // No grant is possible while pc_set_i is high, so only rvalid matters.
      case ({gnt_s, instr_rvalid_i})
         2'b10:   outst_d = outst_q + ONE_C;
         2'b01:   outst_d = outst_q - ONE_C;
         default: outst_d = outst_q;
      endcase

      // Everything still in flight after a redirect cycle is stale.
      if (pc_set_i) begin
         discard_d = instr_rvalid_i ? (outst_q - ONE_C) : outst_q;
      end else if (instr_rvalid_i && (discard_q != {CW{1'b0}})) begin
         discard_d = discard_q - ONE_C;
      end else begin
         discard_d = discard_q;
      end

      if (pc_set_i) begin
         resp_addr_d = aligned_s;
      end else if (push_s) begin
         resp_addr_d = resp_addr_q + 32'd4;
      end else begin
         resp_addr_d = resp_addr_q;
      end

      if (pc_set_i) begin
         cnt_d    = {CW{1'b0}};
         wr_ptr_d = {PW{1'b0}};
         rd_ptr_d = {PW{1'b0}};
      end else begin
         case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + ONE_C;
            2'b01:   cnt_d = cnt_q - ONE_C;
            default: cnt_d = cnt_q;
         endcase
         if (push_s) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? {PW{1'b0}} : (wr_ptr_q + 1'b1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? {PW{1'b0}} : (rd_ptr_q + 1'b1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
      end
   end

   // Control state registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         req_addr_q  <= 32'h0000_0000;
         resp_addr_q <= 32'h0000_0000;
         outst_q     <= {CW{1'b0}};
         discard_q   <= {CW{1'b0}};
         cnt_q       <= {CW{1'b0}};
         wr_ptr_q    <= {PW{1'b0}};
         rd_ptr_q    <= {PW{1'b0}};
      end else begin
         req_addr_q  <= req_addr_d;
         resp_addr_q <= resp_addr_d;
         outst_q     <= outst_d;
         discard_q   <= discard_d;
         cnt_q       <= cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
      end
   end

   // FIFO storage, written at the tail on each accepted response.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < FifoDepth; i++) begin
            data_q[i] <= 32'h0000_0000;
            addr_q[i] <= 32'h0000_0000;
            err_q[i]  <= 1'b0;
         end
      end else if (push_s) begin
         data_q[wr_ptr_q] <= instr_rdata_i;
         addr_q[wr_ptr_q] <= resp_addr_q;
         err_q[wr_ptr_q]  <= instr_err_i;
      end else begin
         data_q[wr_ptr_q] <= data_q[wr_ptr_q];
      end
   end

   assign instr_req_o   = req_s;
   assign instr_addr_o  = req_addr_q;
   assign fetch_valid_o = valid_s;
   // Head fields are masked when empty so popped entries never leak out.
   assign fetch_rdata_o = valid_s ? data_q[rd_ptr_q] : 32'h0000_0000;
   assign fetch_addr_o  = valid_s ? addr_q[rd_ptr_q] : 32'h0000_0000;
   assign fetch_err_o   = valid_s ? err_q[rd_ptr_q]  : 1'b0;
   assign busy_o        = req_s | (outst_q != {CW{1'b0}});

   fetch_req_ctrl_chk u_chk (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .rvalid_i (instr_rvalid_i),
      .idle_i   (outst_q == {CW{1'b0}})
   );

endmodule

// -----------------------------------------------------------------------------
// fetch_req_ctrl_chk
//   Protocol checker: a bus response must never arrive while nothing is
//   outstanding.
//   clk_i, rst_i : clock and reset of the checked block
//   rvalid_i     : bus response valid
//   idle_i       : outstanding counter is zero
// -----------------------------------------------------------------------------
module fetch_req_ctrl_chk (
   input  logic clk_i,
   input  logic rst_i,
   input  logic rvalid_i,
   input  logic idle_i
);

   // Flag responses that have no matching granted request.
   always @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(rvalid_i && idle_i))
            else $error("fetch_req_ctrl: response received with no request outstanding");
      end
   end

endmodule

// File: tb/tb_fetch_req_ctrl.sv
module tb_fetch_req_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_i;
   logic        pc_set_i;
   logic [31:0] fetch_addr_n_i;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i;
   logic        instr_rvalid_i;
   logic [31:0] instr_rdata_i;
   logic        instr_err_i;
   logic        fetch_valid_o;
   logic        fetch_ready_i;
   logic [31:0] fetch_rdata_o;
   logic [31:0] fetch_addr_o;
   logic        fetch_err_o;
   logic        busy_o;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] pend[$];
   logic [31:0] glog[$];
   int          gcount = 0;
   int          errors = 0;
   int          checks = 0;
   logic        hold = 1'b0;

   fetch_req_ctrl dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .req_i          (req_i),
      .pc_set_i       (pc_set_i),
      .fetch_addr_n_i (fetch_addr_n_i),
      .instr_req_o    (instr_req_o),
      .instr_addr_o   (instr_addr_o),
      .instr_gnt_i    (instr_gnt_i),
      .instr_rvalid_i (instr_rvalid_i),
      .instr_rdata_i  (instr_rdata_i),
      .instr_err_i    (instr_err_i),
      .fetch_valid_o  (fetch_valid_o),
      .fetch_ready_i  (fetch_ready_i),
      .fetch_rdata_o  (fetch_rdata_o),
      .fetch_addr_o   (fetch_addr_o),
      .fetch_err_o    (fetch_err_o),
      .busy_o         (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_entry(input logic [31:0] a, input logic [31:0] d, input logic e);
      exp_t x;
      x.addr = a;
      x.data = d;
      x.err  = e;
      sb.push_back(x);
   endtask

   // Grant sampler: a request seen with grant at the falling edge is taken at the next rising edge.
   always @(negedge clk_i) begin
      if (!rst_i && instr_req_o && instr_gnt_i) begin
         pend.push_back(instr_addr_o);
         glog.push_back(instr_addr_o);
         gcount++;
      end
   end

   // Bus responder: answers each granted address one cycle later unless held.
   initial begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = 32'h0;
      instr_err_i    = 1'b0;
      forever begin
         @(posedge clk_i);
         #2;
         if (!rst_i && !hold && pend.size() > 0) begin
            logic [31:0] a;
            a = pend.pop_front();
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = a ^ 32'hA5A5_0000;
            instr_err_i    = (a == 32'hFFFF_FFFC);
         end else begin
            instr_rvalid_i = 1'b0;
            instr_err_i    = 1'b0;
         end
      end
   end

   // Monitor: every accepted head entry is checked against the scoreboard.
   always @(negedge clk_i) begin
      if (!rst_i && fetch_valid_o && fetch_ready_i && !pc_set_i) begin
         if (sb.size() == 0) begin
            chk("unexpected_entry_addr", fetch_addr_o, 32'hxxxx_xxxx);
         end else begin
            exp_t x;
            x = sb.pop_front();
            chk("head_addr", fetch_addr_o, x.addr);
            chk("head_rdata", fetch_rdata_o, x.data);
            chk("head_err", {31'd0, fetch_err_o}, {31'd0, x.err});
         end
      end
   end

   task automatic redirect(input logic [31:0] a);
      @(posedge clk_i);
      #1;
      pc_set_i = 1'b1;
      fetch_addr_n_i = a;
      @(negedge clk_i);
      chk("no_req_during_pc_set", {31'd0, instr_req_o}, 32'd0);
      @(posedge clk_i);
      #1;
      pc_set_i = 1'b0;
   endtask

   task automatic issue_n(input int n);
      int start;
      bit done;
      start = gcount;
      done = 1'b0;
      req_i = 1'b1;
      for (int i = 0; i < 60 && !done; i++) begin
         @(posedge clk_i);
         #1;
         if (gcount - start >= n) done = 1'b1;
      end
      req_i = 1'b0;
      chk("grant_count_reached", {31'd0, done}, 32'd1);
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk_i);
         if (sb.size() == 0 && !busy_o && !fetch_valid_o) done = 1'b1;
      end
      chk("drain_idle", {31'd0, done}, 32'd1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"},   {31'd0, instr_req_o},   32'd0);
      chk({tag, "_addr"},  instr_addr_o,           32'd0);
      chk({tag, "_valid"}, {31'd0, fetch_valid_o}, 32'd0);
      chk({tag, "_rdata"}, fetch_rdata_o,          32'd0);
      chk({tag, "_faddr"}, fetch_addr_o,           32'd0);
      chk({tag, "_ferr"},  {31'd0, fetch_err_o},   32'd0);
      chk({tag, "_busy"},  {31'd0, busy_o},        32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      rst_i = 1'b1;
      req_i = 1'b1;
      pc_set_i = 1'b0;
      fetch_addr_n_i = 32'h0;
      instr_gnt_i = 1'b1;
      fetch_ready_i = 1'b1;
      #3;
      chk_all_zero("reset");
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      req_i = 1'b0;

      // Sequential fetch from an unaligned redirect target.
      glog.delete();
      expect_entry(32'h0000_0080, 32'hA5A5_0080, 1'b0);
      expect_entry(32'h0000_0084, 32'hA5A5_0084, 1'b0);
      expect_entry(32'h0000_0088, 32'hA5A5_0088, 1'b0);
      redirect(32'h0000_0083);
      issue_n(3);
      chk("seq_gnt0", glog[0], 32'h0000_0080);
      chk("seq_gnt1", glog[1], 32'h0000_0084);
      chk("seq_gnt2", glog[2], 32'h0000_0088);
      wait_idle();

      // Backpressure: FIFO space limits grants to two.
      glog.delete();
      fetch_ready_i = 1'b0;
      expect_entry(32'h0000_0080, 32'hA5A5_0080, 1'b0);
      expect_entry(32'h0000_0084, 32'hA5A5_0084, 1'b0);
      expect_entry(32'h0000_0088, 32'hA5A5_0088, 1'b0);
      redirect(32'h0000_0080);
      req_i = 1'b1;
      repeat (10) @(posedge clk_i);
      @(negedge clk_i);
      chk("bp_grants", glog.size(), 32'd2);
      chk("bp_req_low", {31'd0, instr_req_o}, 32'd0);
      chk("bp_valid", {31'd0, fetch_valid_o}, 32'd1);
      chk("bp_head_addr", fetch_addr_o, 32'h0000_0080);
      chk("bp_busy_low", {31'd0, busy_o}, 32'd0);
      @(posedge clk_i);
      #1;
      fetch_ready_i = 1'b1;
      issue_n(1);
      chk("bp_resume_addr", glog[2], 32'h0000_0088);
      wait_idle();

      // Redirect with two responses outstanding.
      glog.delete();
      hold = 1'b1;
      expect_entry(32'h0000_0200, 32'hA5A5_0200, 1'b0);
      redirect(32'h0000_0100);
      issue_n(2);
      chk("rd_gnt0", glog[0], 32'h0000_0100);
      chk("rd_gnt1", glog[1], 32'h0000_0104);
      redirect(32'h0000_0200);
      hold = 1'b0;
      @(negedge clk_i);
      chk("rd_fifo_empty", {31'd0, fetch_valid_o}, 32'd0);
      issue_n(1);
      chk("rd_new_gnt", glog[2], 32'h0000_0200);
      wait_idle();

      // Grant stall holds the request and its address.
      glog.delete();
      expect_entry(32'h0000_0080, 32'hA5A5_0080, 1'b0);
      expect_entry(32'h0000_0084, 32'hA5A5_0084, 1'b0);
      redirect(32'h0000_0080);
      issue_n(1);
      instr_gnt_i = 1'b0;
      req_i = 1'b1;
      repeat (3) begin
         @(negedge clk_i);
         chk("stall_addr", instr_addr_o, 32'h0000_0084);
         chk("stall_req", {31'd0, instr_req_o}, 32'd1);
      end
      chk("stall_no_grant", glog.size(), 32'd1);
      @(posedge clk_i);
      #1;
      instr_gnt_i = 1'b1;
      issue_n(1);
      chk("stall_resume_addr", glog[1], 32'h0000_0084);
      wait_idle();

      // Address wrap and error tagging.
      glog.delete();
      expect_entry(32'hFFFF_FFFC, 32'h5A5A_FFFC, 1'b1);
      redirect(32'hFFFF_FFFF);
      issue_n(1);
      chk("wrap_gnt", glog[0], 32'hFFFF_FFFC);
      wait_idle();
      chk("wrap_next_addr", instr_addr_o, 32'h0000_0000);
`ifdef FETCH_ERR_STOP_EN
      req_i = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk_i);
         if (instr_req_o) seen = 1'b1;
      end
      chk("errstop_no_req", {31'd0, seen}, 32'd0);
      chk("errstop_no_grant", glog.size(), 32'd1);
      req_i = 1'b0;
      expect_entry(32'h0000_0000, 32'hA5A5_0000, 1'b0);
      redirect(32'h0000_0000);
      issue_n(1);
`else
      expect_entry(32'h0000_0000, 32'hA5A5_0000, 1'b0);
      issue_n(1);
`endif
      chk("wrap_zero_gnt", glog[1], 32'h0000_0000);
      wait_idle();

      // Asynchronous reset with one entry buffered and one response outstanding.
      glog.delete();
      fetch_ready_i = 1'b0;
      redirect(32'h0000_0300);
      issue_n(1);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk_i);
         if (fetch_valid_o) seen = 1'b1;
      end
      chk("ar_entry_buffered", {31'd0, seen}, 32'd1);
      @(posedge clk_i);
      #1;
      hold = 1'b1;
      issue_n(1);
      chk("ar_second_gnt", glog[1], 32'h0000_0304);
      req_i = 1'b1;
      @(posedge clk_i);
      #3;
      rst_i = 1'b1;
      #1;
      chk_all_zero("async_reset");
      pend.delete();
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      req_i = 1'b0;
      hold = 1'b0;
      fetch_ready_i = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk_i);
         if (fetch_valid_o || busy_o) seen = 1'b1;
      end
      chk("ar_no_stale", {31'd0, seen}, 32'd0);
      chk("scoreboard_empty", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
